// File: rtl/signal_ram_loader.sv
// Packs NUM_LANES channel samples into one RAM word and writes a full frame of 2^ADDR_W words.
// Optional build macro LOADER_OFFSET_BINARY_EN flips each sample MSB (offset-binary -> two's complement).

module signal_ram_loader_lane #(
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [SAMPLE_W-1:0] d,
  output logic [SAMPLE_W-1:0] q
);
  logic [SAMPLE_W-1:0] lane_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  lane_q <= '0;
    else if (we) lane_q <= d;
  end

  assign q = lane_q;
endmodule

module signal_ram_loader #(
  parameter int NUM_LANES = 8,
  parameter int SAMPLE_W  = 16,
  parameter int ADDR_W    = 11
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [SAMPLE_W-1:0]           sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic [ADDR_W-1:0]             ram_address,
  output logic [NUM_LANES*SAMPLE_W-1:0] ram_data,
  output logic                          ram_wren,
  output logic                          load_done,
  output logic                          busy
);
  localparam int LIDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(NUM_LANES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_PACK, S_WRITE, S_DONE} state_t;

  state_t                               state_q, state_d;
  logic [LIDX_W-1:0]                    lane_idx_q, lane_idx_d;
  logic [ADDR_W-1:0]                    addr_q, addr_d;
  logic                                 sample_ready_q, ram_wren_q, load_done_q, busy_q;
  logic [NUM_LANES-1:0]                 lane_we;
  logic [NUM_LANES-1:0][SAMPLE_W-1:0]   lane_q;
  logic [SAMPLE_W-1:0]                  sample_conv;

`ifdef LOADER_OFFSET_BINARY_EN
  assign sample_conv = sample_in ^ {1'b1, {(SAMPLE_W-1){1'b0}}};
`else
  assign sample_conv = sample_in;
`endif

  // Lane registers double as the RAM data word; they only change in PACK, so data is stable in WRITE.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    signal_ram_loader_lane #(.SAMPLE_W(SAMPLE_W)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (lane_we[g]),
      .d    (sample_conv),
      .q    (lane_q[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    lane_idx_d = lane_idx_q;
    addr_d     = addr_q;
    lane_we    = '0;
    if (abort) begin
      state_d    = S_IDLE;
      lane_idx_d = '0;
      addr_d     = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d    = S_PACK;
            lane_idx_d = '0;
            addr_d     = '0;
          end
        end
        S_PACK: begin
          if (sample_valid) begin
            lane_we[lane_idx_q] = 1'b1;
            if (lane_idx_q == LAST_LANE) state_d = S_WRITE;
            else                         lane_idx_d = lane_idx_q + LIDX_W'(1);
          end
        end
        S_WRITE: begin
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_PACK;
            addr_d     = addr_q + ADDR_W'(1);
            lane_idx_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      lane_idx_q     <= '0;
      addr_q         <= '0;
      sample_ready_q <= 1'b0;
      ram_wren_q     <= 1'b0;
      load_done_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      lane_idx_q     <= lane_idx_d;
      addr_q         <= addr_d;
      sample_ready_q <= (state_d == S_PACK);
      ram_wren_q     <= (state_d == S_WRITE);
      load_done_q    <= (state_d == S_DONE);
      busy_q         <= (state_d == S_PACK) || (state_d == S_WRITE);
    end
  end

  assign sample_ready = sample_ready_q;
  assign ram_wren     = ram_wren_q;
  assign load_done    = load_done_q;
  assign busy         = busy_q;
  assign ram_address  = addr_q;
  assign ram_data     = lane_q;
endmodule

// File: tb/tb_signal_ram_loader.sv
// Scoreboard bench for signal_ram_loader: sample stream model predicts RAM writes, a monitor checks them.

module tb_signal_ram_loader;
  localparam int NL = 8;
  localparam int SW = 16;
  localparam int AW = 11;
  localparam int DW = NL * SW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [SW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic          load_done;
  logic          busy;

  signal_ram_loader #(.NUM_LANES(NL), .SAMPLE_W(SW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .load_done(load_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_fail = 0;

  // Reference model: accepted samples in order; every NL samples form the word for the next address.
  logic [SW-1:0] m_lanes[$];
  int            m_addr = 0;
  bit            m_track = 1'b1;
  bit            tgl = 1'b0;

  function automatic logic [SW-1:0] conv(input logic [SW-1:0] s);
`ifdef LOADER_OFFSET_BINARY_EN
    return s ^ 16'h8000;
`else
    return s;
`endif
  endfunction

  task automatic model_restart();
    m_lanes.delete();
    m_addr = 0;
  endtask

  task automatic model_accept(input logic [SW-1:0] s);
    wr_t w;
    m_lanes.push_back(conv(s));
    if (m_lanes.size() == NL) begin
      w.a = AW'(m_addr);
      w.d = '0;
      for (int k = 0; k < NL; k++) w.d[k*SW +: SW] = m_lanes[k];
      if (m_track && m_addr < (1 << AW)) exp_q.push_back(w);
      m_addr++;
      m_lanes.delete();
    end
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // mode 0: valid every cycle, 1: random gaps, 2: toggling valid
  task automatic send(input logic [SW-1:0] s, input int mode);
    bit done = 1'b0;
    int guard = 0;
    while (!done) begin
      @(negedge clk);
      case (mode)
        0: sample_valid = 1'b1;
        1: sample_valid = ($urandom_range(99) < 60);
        default: begin sample_valid = tgl; tgl = ~tgl; end
      endcase
      sample_in = s;
      done = sample_valid && sample_ready;
      guard++;
      if (!done && guard > 200) begin
        n_cmp++; n_fail++;
        $display("FAIL send_timeout: sample %0h never accepted", s);
        sample_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1 sample_valid = 1'b0;
    model_accept(s);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_abort(input bit with_start);
    @(negedge clk) begin abort = 1'b1; start = with_start; end
    @(negedge clk) begin abort = 1'b0; start = 1'b0; end
  endtask

  // Monitor: every observed write must match the head of the expected queue.
  bit prev_wren = 1'b0;
  always @(negedge clk) begin
    wr_t e;
    if (ram_wren === 1'b1) begin
      chk("wren_outside_pack", sample_ready, 0);
      chk("wren_single_cycle", prev_wren, 0);
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h expected none", ram_address, ram_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", ram_address, e.a);
        chk("wr_data", ram_data, e.d);
      end
    end
    prev_wren = (ram_wren === 1'b1);
  end

  initial begin
    // Reset values
    @(negedge clk);
    chk("rst_wren", ram_wren, 0);
    chk("rst_ready", sample_ready, 0);
    chk("rst_done", load_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_data", ram_data, 0);
    @(negedge clk) rst_n = 1'b1;

    // Back-to-back word 1..8
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_ready", sample_ready, 1);
    model_restart();
    for (int i = 1; i <= 8; i++) send(SW'(i), 0);
    @(negedge clk);
    chk("write_latency", ram_wren, 1);
    @(negedge clk);
    chk("back_to_pack_ready", sample_ready, 1);
    chk("back_to_pack_busy", busy, 1);
    chk("addr_incr", ram_address, 1);

    // Random words with gaps, including an ignored start while busy
    for (int w = 0; w < 4; w++)
      for (int i = 0; i < NL; i++) begin
        send(SW'($urandom), 1);
        if (w == 1 && i == 3) pulse_start();
      end

    // Toggling valid gives the same packed word as back-to-back
    for (int i = 1; i <= 8; i++) send(SW'(i), 2);

`ifdef LOADER_OFFSET_BINARY_EN
    send(16'h8000, 0);
    send(16'h7FFF, 0);
    for (int i = 0; i < 6; i++) send(SW'($urandom), 0);
    @(negedge clk);
    chk("ofs_lane0", ram_data[15:0], 16'h0000);
    chk("ofs_lane1", ram_data[31:16], 16'hFFFF);
`endif

    // Abort together with start: abort wins
    pulse_abort(1'b1);
    chk("abort_start_busy", busy, 0);
    chk("abort_start_ready", sample_ready, 0);
    model_restart();

    // Abort after lane 5 of word 3, then reload from address 0
    pulse_start();
    for (int i = 0; i < 3 * NL + 6; i++) send(SW'($urandom), 1);
    pulse_abort(1'b0);
    chk("abort_busy", busy, 0);
    chk("abort_addr", ram_address, 0);
    model_restart();
    pulse_start();
    for (int i = 0; i < NL; i++) send(SW'($urandom), 1);

    // Reset pulse of half a cycle in the middle of WRITE
    m_track = 1'b0;
    for (int i = 0; i < NL; i++) send(SW'($urandom), 0);
    chk("pre_rst_wren", ram_wren, 1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_wren", ram_wren, 0);
    chk("midrst_ready", sample_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", load_done, 0);
    chk("midrst_addr", ram_address, 0);
    chk("midrst_data", ram_data, 0);
    #2 rst_n = 1'b1;
    m_track = 1'b1;
    model_restart();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("first_edge_start", busy, 1);

    // Full frame, valid held high
    for (int i = 0; i < NL * (1 << AW); i++) send(SW'($urandom), 0);
    @(negedge clk);
    chk("last_write_wren", ram_wren, 1);
    chk("last_write_addr", ram_address, (1 << AW) - 1);
    @(negedge clk);
    chk("done_after_last", load_done, 1);
    chk("done_wren", ram_wren, 0);
    chk("done_ready", sample_ready, 0);
    repeat (4) @(negedge clk);
    chk("done_held", load_done, 1);
    chk("frame_drained", exp_q.size(), 0);

    // Restart from DONE, then abort during WRITE
    pulse_start();
    chk("restart_done_clr", load_done, 0);
    chk("restart_busy", busy, 1);
    model_restart();
    for (int i = 0; i < NL; i++) send(SW'($urandom), 0);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_write_wren", ram_wren, 0);
    chk("abort_write_busy", busy, 0);
    chk("abort_write_addr", ram_address, 0);
    model_restart();

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
